vrf_rd_streamer: RTL and testbench

Read-side streaming front end for the vector register file SRAM (`tc_sram`, one port). It accepts a burst read command (start word, length), issues one SRAM read request per cycle on its port, aligns returning `rdata` with the fixed SRAM read latency, and delivers the words as a valid/ready stream with a last flag to the tensor-core datapath. A credit counter guarantees that no returned word is ever dropped under downstream backpressure.

---
 rtl/vrf_rd_streamer.sv | 164 ++++++++++++++++
 tb/tb_vrf_rd_streamer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_rd_streamer.sv
// Burst read streamer for the single-port VRF SRAM: issues one read per cycle,
// realigns rdata to the fixed read latency and buffers it behind a credit counter.
module vrf_rd_streamer #(
  parameter int unsigned NumWords  = 128,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Latency   = 1,
  parameter int unsigned FifoDepth = 4,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth   = (DataWidth + 7) / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [AddrWidth:0]   cmd_len_i,
  output logic                 req_o,
  output logic                 we_o,
  output logic [BeWidth-1:0]   be_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [DataWidth-1:0] wdata_o,
  input  logic [DataWidth-1:0] rdata_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_last_o,
  output logic                 busy_o
);

  localparam int unsigned CntWidth = $clog2(FifoDepth + 1);
  localparam int unsigned PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  if (FifoDepth < Latency + 1) begin : g_bad_depth
    $fatal(1, "vrf_rd_streamer: FifoDepth must be >= Latency + 1");
  end
  if (Latency < 1 || Latency > 4) begin : g_bad_latency
    $fatal(1, "vrf_rd_streamer: Latency must be in 1..4");
  end

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                 state_q, state_d;
  logic [AddrWidth-1:0]   cur_addr_q, cur_addr_d;
  logic [AddrWidth:0]     remaining_q, remaining_d;
  logic [CntWidth-1:0]    credits_q;
  logic [Latency-1:0]     tag_valid_q, tag_last_q;
  logic [DataWidth-1:0]   fifo_data_q [FifoDepth];
  logic [FifoDepth-1:0]   fifo_last_q;
  logic [PtrWidth-1:0]    wptr_q, rptr_q;
  logic [CntWidth-1:0]    count_q;
  logic                   issue, issue_last, push, pop, empty;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(FifoDepth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    cmd_ready_o = 1'b0;
    issue       = 1'b0;
    issue_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready_o = !rst_i;
        if (cmd_valid_i && cmd_len_i != '0) begin
          cur_addr_d  = cmd_addr_i;
          remaining_d = cmd_len_i;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        issue = (credits_q != '0) && !rst_i;
        if (issue) begin
          cur_addr_d  = (cur_addr_q == AddrWidth'(NumWords - 1)) ? '0 : cur_addr_q + AddrWidth'(1);
          remaining_d = remaining_q - (AddrWidth + 1)'(1);
          if (remaining_q == (AddrWidth + 1)'(1)) begin
            issue_last = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
    end
  end

  assign req_o   = issue;
  assign addr_o  = issue ? cur_addr_q : '0;
  assign we_o    = 1'b0;
  assign be_o    = '0;
  assign wdata_o = '0;

  // Tag pipe mirrors the SRAM latency so each tag surfaces with its rdata.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_valid_q <= '0;
      tag_last_q  <= '0;
    end else begin
      tag_valid_q[0] <= issue;
      tag_last_q[0]  <= issue_last;
      for (int unsigned i = 1; i < Latency; i++) begin
        tag_valid_q[i] <= tag_valid_q[i-1];
        tag_last_q[i]  <= tag_last_q[i-1];
      end
    end
  end

  assign push  = tag_valid_q[Latency-1];
  assign empty = (count_q == '0);
  assign out_valid_o = !empty && !rst_i;
  assign pop   = out_valid_o && out_ready_i;
  assign out_data_o = out_valid_o ? fifo_data_q[rptr_q] : '0;
  assign out_last_o = out_valid_o ? fifo_last_q[rptr_q] : 1'b0;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wptr_q] <= rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      fifo_last_q <= '0;
      credits_q   <= CntWidth'(FifoDepth);
    end else begin
      if (push) begin
        fifo_last_q[wptr_q] <= tag_last_q[Latency-1];
        wptr_q              <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CntWidth'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntWidth'(1);
      end
      if (issue && !pop) begin
        credits_q <= credits_q - CntWidth'(1);
      end else if (pop && !issue) begin
        credits_q <= credits_q + CntWidth'(1);
      end
    end
  end

  assign busy_o = !rst_i && ((state_q == ISSUE) || (|tag_valid_q) || !empty);

endmodule

// File: tb/tb_vrf_rd_streamer.sv
// Bench for vrf_rd_streamer: four instances (Latency 1..4) share stimulus, each
// scored against a queue model of expected requests and beats.
module tb_vrf_rd_streamer;

  localparam int NW = 128;
  localparam int DW = 32;
  localparam int ND = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic       out_ready = 1'b1;

  logic        cmd_ready [ND];
  logic        req       [ND];
  logic        we        [ND];
  logic [3:0]  be        [ND];
  logic [6:0]  addr      [ND];
  logic [31:0] wdata     [ND];
  logic [31:0] rdata     [ND];
  logic        out_valid [ND];
  logic [31:0] out_data  [ND];
  logic        out_last  [ND];
  logic        busy      [ND];
  int          pend      [ND];

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [6:0] a);
    return 32'h100 + 32'(a);
  endfunction

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  for (genvar k = 0; k < ND; k++) begin : g
    localparam int unsigned LAT = k + 1;
    localparam int unsigned FD  = (k == 0) ? 4 : (k == 3) ? 6 : k + 2;

    logic [31:0]  pipe [LAT];
    int unsigned  aq [$];
    logic [32:0]  dq [$];
    int           outst = 0;

    vrf_rd_streamer #(
      .NumWords (NW),
      .DataWidth(DW),
      .Latency  (LAT),
      .FifoDepth(FD)
    ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .cmd_valid_i(cmd_valid),
      .cmd_ready_o(cmd_ready[k]),
      .cmd_addr_i (cmd_addr),
      .cmd_len_i  (cmd_len),
      .req_o      (req[k]),
      .we_o       (we[k]),
      .be_o       (be[k]),
      .addr_o     (addr[k]),
      .wdata_o    (wdata[k]),
      .rdata_i    (rdata[k]),
      .out_valid_o(out_valid[k]),
      .out_ready_i(out_ready),
      .out_data_o (out_data[k]),
      .out_last_o (out_last[k]),
      .busy_o     (busy[k])
    );

    // SRAM model: word[i] = 0x100 + i, returned LAT cycles after the request.
    assign rdata[k] = pipe[LAT-1];
    always @(posedge clk) begin
      pipe[0] <= req[k] ? word(addr[k]) : 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    always @(negedge clk) begin
      if (rst) begin
        aq.delete();
        dq.delete();
        outst = 0;
      end else begin
        chk("busy", k, busy[k], dq.size() != 0);
        chk("const_zero", k, {we[k], be[k], wdata[k]}, '0);
        if (req[k]) begin
          chk("req_pending", k, aq.size() != 0, 1'b1);
          if (aq.size() != 0) chk("req_addr", k, addr[k], aq.pop_front());
          outst++;
        end else begin
          chk("addr_idle", k, addr[k], '0);
        end
        if (out_valid[k] && out_ready) begin
          chk("pop_pending", k, dq.size() != 0, 1'b1);
          if (dq.size() != 0) chk("beat", k, {out_last[k], out_data[k]}, dq.pop_front());
          outst--;
        end
        if (!out_valid[k]) chk("out_idle", k, {out_last[k], out_data[k]}, '0);
        chk("credit_bound", k, outst <= int'(FD), 1'b1);
        if (cmd_valid && cmd_ready[k]) begin
          for (int i = 0; i < int'(cmd_len); i++) begin
            logic [6:0] a;
            a = 7'((int'(cmd_addr) + i) % NW);
            aq.push_back(int'(a));
            dq.push_back({(i == int'(cmd_len) - 1), word(a)});
          end
        end
      end
      pend[k] = dq.size();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      done = 1;
      for (int k = 0; k < ND; k++) if (busy[k] || pend[k] != 0) done = 0;
    end
    chk("drain_timeout", 0, done, 1'b1);
  endtask

  task automatic rst_vals();
    for (int k = 0; k < ND; k++)
      chk("reset_state", k,
          {cmd_ready[k], req[k], out_valid[k], out_last[k], busy[k], addr[k], out_data[k]},
          {20'b0, 1'b1, 43'b0});
  endtask

  logic [6:0]  t4_exp [4];
  logic [32:0] bt [4];

  initial begin
    int nreq, npop, nb;
    bit act;

    repeat (3) tick();
    @(negedge clk);
    chk("ready_in_reset", 0, cmd_ready[0], 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    rst_vals();

    // Single beat: request in cycle 1, beat in cycle 3.
    tick(); cmd_valid = 1; cmd_addr = 5; cmd_len = 1;
    @(negedge clk); chk("t1_cmd_ready", 0, cmd_ready[0], 1'b1);
    tick(); cmd_valid = 0;
    @(negedge clk); chk("t1_req", 0, {req[0], addr[0]}, {1'b1, 7'd5});
    tick();
    @(negedge clk); chk("t1_no_beat_yet", 0, out_valid[0], 1'b0);
    tick();
    @(negedge clk); chk("t1_beat", 0, {out_valid[0], out_last[0], out_data[0]}, {1'b1, 1'b1, 32'h105});
    drain();

    // Four beats at full rate.
    tick(); cmd_valid = 1; cmd_addr = 10; cmd_len = 4;
    for (int c = 1; c <= 6; c++) begin
      tick();
      cmd_valid = 0;
      @(negedge clk);
      if (c <= 4) chk("t2_req", 0, {req[0], addr[0]}, {1'b1, 7'(9 + c)});
      else        chk("t2_req_end", 0, req[0], 1'b0);
      if (c >= 3) chk("t2_beat", 0, {out_valid[0], out_last[0], out_data[0]},
                      {1'b1, (c == 6), 32'(32'h10A + c - 3)});
      else        chk("t2_no_beat", 0, out_valid[0], 1'b0);
    end
    drain();

    // Backpressure: credits cap outstanding requests at FifoDepth.
    tick(); out_ready = 0; cmd_valid = 1; cmd_addr = 0; cmd_len = 16;
    nreq = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      cmd_valid = 0;
      @(negedge clk);
      if (req[0]) nreq++;
    end
    chk("t3_req_count", 0, nreq, 4);
    chk("t3_req_held", 0, req[0], 1'b0);
    tick(); out_ready = 1;
    npop = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid[0] && out_ready) npop++;
      if (!busy[0]) break;
    end
    chk("t3_beat_count", 0, npop, 16);
    drain();

    // Address wrap and zero-length command.
    t4_exp[0] = 126; t4_exp[1] = 127; t4_exp[2] = 0; t4_exp[3] = 1;
    tick(); cmd_valid = 1; cmd_addr = 126; cmd_len = 4;
    for (int c = 1; c <= 4; c++) begin
      tick();
      cmd_valid = 0;
      @(negedge clk);
      chk("t4_wrap_addr", 0, {req[0], addr[0]}, {1'b1, t4_exp[c-1]});
    end
    drain();
    tick(); cmd_valid = 1; cmd_addr = 9; cmd_len = 0;
    @(negedge clk); chk("t4_len0_ready", 0, cmd_ready[0], 1'b1);
    act = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      cmd_valid = 0;
      @(negedge clk);
      act |= req[0] | out_valid[0] | busy[0];
    end
    chk("t4_len0_quiet", 0, act, 1'b0);

    // Reset mid-burst discards everything pending.
    tick(); cmd_valid = 1; cmd_addr = 0; cmd_len = 16;
    npop = 0;
    for (int i = 0; i < 50 && npop < 3; i++) begin
      tick();
      cmd_valid = 0;
      @(negedge clk);
      if (out_valid[0] && out_ready) npop++;
    end
    chk("t5_three_beats", 0, npop, 3);
    tick(); rst = 1;
    @(negedge clk); chk("t5_ready_in_reset", 0, cmd_ready[0], 1'b0);
    tick(); rst = 0;
    @(negedge clk); rst_vals();
    tick(); cmd_valid = 1; cmd_addr = 2; cmd_len = 2;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cmd_valid = 0;
      @(negedge clk);
      if (out_valid[0] && out_ready && nb < 4) begin
        bt[nb] = {out_last[0], out_data[0]};
        nb++;
      end
    end
    chk("t5_beat_count", 0, nb, 2);
    chk("t5_beat0", 0, bt[0], {1'b0, 32'h102});
    chk("t5_beat1", 0, bt[1], {1'b1, 32'h103});
    drain();

    // Random commands and backpressure across all latencies.
    for (int i = 0; i < 8000; i++) begin
      tick();
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_addr  = 7'($urandom_range(0, 127));
      cmd_len   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 128)) : 8'($urandom_range(0, 12));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    tick(); cmd_valid = 0; out_ready = 1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
